// File: rtl/des_perm_pipe_if.sv
// Stream interface for des_perm_pipe: input block handshake, output block
// handshake and the delivered-block counter. The engine uses the slave view.
interface des_perm_pipe_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [1:64]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:64]      out_data;
    logic [1:32]      out_left;
    logic [1:32]      out_right;
    logic [1:0]       out_mode;
    logic [CNT_W-1:0] blk_count;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_left, out_right, out_mode, blk_count
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_left, out_right, out_mode, blk_count
    );
endinterface

// File: rtl/des_perm_pipe.sv
// Pipelined DES initial / final bit permutation with a valid/ready elastic
// pipeline of STAGES registers, a per-block mode and a delivered-block counter.
// Optional feature: define DES_PERM_BYPASS_EN to make mode 2'b10 pass the block
// through unpermuted; without it mode 2'b10 is treated as IP.
module des_perm_pipe #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input logic            clk,
    input logic            rst,
    des_perm_pipe_if.slave bus
);

    localparam int unsigned LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("des_perm_pipe: STAGES must be in 1..4");
    end

    // Bit 1 is the MSB throughout; tables follow the DES numbering directly.
    function automatic logic [1:64] perm_ip(input logic [1:64] d);
        logic [1:64] p;
        p = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (r < 4) p[8*r+c+1] = d[58+2*r-8*c];
                else       p[8*r+c+1] = d[57+2*(r-4)-8*c];
            end
        end
        return p;
    endfunction

    function automatic logic [1:64] perm_fp(input logic [1:64] d);
        logic [1:64] p;
        p = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (c % 2 == 0) p[8*r+c+1] = d[40+4*c-r];
                else            p[8*r+c+1] = d[4*c+4-r];
            end
        end
        return p;
    endfunction

    logic [STAGES-1:0] valid_q, valid_d;
    logic [1:0]        mode_q [STAGES];
    logic [1:0]        mode_d [STAGES];
    logic [1:64]       data_q [STAGES];
    logic [1:64]       data_d [STAGES];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STAGES-1:0] adv;
    logic              in_ready_c;
    logic [1:64]       perm_data;

    // Select the permutation for the incoming block; reserved modes fall back to IP.
    always_comb begin
        perm_data = perm_ip(bus.in_data);
        case (bus.in_mode)
            2'b01:   perm_data = perm_fp(bus.in_data);
`ifdef DES_PERM_BYPASS_EN
            2'b10:   perm_data = bus.in_data;
`endif
            default: perm_data = perm_ip(bus.in_data);
        endcase
    end

    // Backward ready chain: a stage advances if the one after it is empty or advancing.
    always_comb begin
        logic ok;
        logic a;
        ok  = bus.out_ready;
        adv = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            a      = valid_q[k] && ok;
            adv[k] = a;
            ok     = !valid_q[k] || a;
        end
        in_ready_c = ok;
    end

    // Next-state for each stage; payload only loads when a valid block moves in.
    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        data_d  = data_q;
        if (in_ready_c) begin
            valid_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                mode_d[0] = bus.in_mode;
                data_d[0] = perm_data;
            end
        end
        for (int k = 1; k < int'(STAGES); k++) begin
            if (!valid_q[k] || adv[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    mode_d[k] = mode_q[k-1];
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    // Delivered-block counter, wraps naturally at 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q[LAST] && bus.out_ready) cnt_d = cnt_q + CNT_W'(1);
    end

    // State registers with synchronous reset discarding all in-flight blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            mode_q  <= '{default: '0};
            data_q  <= '{default: '0};
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q[LAST];
    assign bus.out_data  = data_q[LAST];
    assign bus.out_left  = data_q[LAST][1:32];
    assign bus.out_right = data_q[LAST][33:64];
    assign bus.out_mode  = mode_q[LAST];
    assign bus.blk_count = cnt_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe (STAGES=2, CNT_W=4).
module tb_des_perm_pipe;

    localparam int unsigned STAGES = 2;
    localparam int unsigned CNT_W  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_perm_pipe_if #(.CNT_W(CNT_W)) bus ();

    des_perm_pipe #(
        .STAGES(STAGES),
        .CNT_W (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_cnt;

    // Hand-computed IP/FP pairs, alternating modes.
    logic [63:0] vin   [8] = '{64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA,
                               64'h8000000000000000, 64'h0000000001000000,
                               64'h0000000000000040, 64'h8000000000000000,
                               64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000};
    logic [1:0]  vmode [8] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [63:0] vexp  [8] = '{64'hCC00CCFFF0AAF0AA, 64'h0123456789ABCDEF,
                               64'h0000000001000000, 64'h8000000000000000,
                               64'h8000000000000000, 64'h0000000000000040,
                               64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000};

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    // Drives one block and waits (bounded) for it; returns lat=-1 on timeout.
    task automatic do_block(input logic [1:0] m, input logic [63:0] d,
                            output logic [63:0] od, output logic [1:0] om, output int lat);
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_mode   = m;
        bus.in_data   = d;
        bus.out_ready = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 64'hDEADBEEF0BADF00D;
        bus.in_mode  = 2'b01;
        #1;
        n   = 1;
        lat = -1;
        od  = 'x;
        om  = 'x;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (bus.out_valid) begin
            lat = n;
            od  = bus.out_data;
            om  = bus.out_mode;
            exp_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        #1;
        checks++; if (bus.out_valid !== 1'b0)
            begin failures++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 64'h0)
            begin failures++; $display("FAIL rst_out_data got %h want 0", bus.out_data); end
        checks++; if (bus.out_left !== 32'h0 || bus.out_right !== 32'h0)
            begin failures++; $display("FAIL rst_out_lr got %h/%h want 0/0", bus.out_left, bus.out_right); end
        checks++; if (bus.out_mode !== 2'b00)
            begin failures++; $display("FAIL rst_out_mode got %b want 00", bus.out_mode); end
        checks++; if (bus.blk_count !== 4'd0)
            begin failures++; $display("FAIL rst_blk_count got %0d want 0", bus.blk_count); end
        checks++; if (bus.in_ready !== 1'b1)
            begin failures++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_ip();
        logic [63:0] od;
        logic [1:0]  om;
        int          lat;
        do_block(2'b00, 64'h0123456789ABCDEF, od, om, lat);
        checks++; if (lat !== int'(STAGES))
            begin failures++; $display("FAIL ip_latency got %0d want %0d", lat, STAGES); end
        checks++; if (od !== 64'hCC00CCFFF0AAF0AA)
            begin failures++; $display("FAIL ip_data got %h want cc00ccfff0aaf0aa", od); end
        checks++; if (bus.out_left !== 32'hCC00CCFF)
            begin failures++; $display("FAIL ip_left got %h want cc00ccff", bus.out_left); end
        checks++; if (bus.out_right !== 32'hF0AAF0AA)
            begin failures++; $display("FAIL ip_right got %h want f0aaf0aa", bus.out_right); end
        checks++; if (om !== 2'b00)
            begin failures++; $display("FAIL ip_mode got %b want 00", om); end
        @(negedge clk);
        #1;
        checks++; if (bus.blk_count !== 4'd1)
            begin failures++; $display("FAIL ip_blk_count got %0d want 1", bus.blk_count); end
    endtask

    task automatic test_modes();
        logic [63:0] od;
        logic [1:0]  om;
        logic [63:0] bexp;
        int          lat;
        do_block(2'b01, 64'hCC00CCFFF0AAF0AA, od, om, lat);
        checks++; if (od !== 64'h0123456789ABCDEF || om !== 2'b01)
            begin failures++; $display("FAIL fp_data got %h/%b want 0123456789abcdef/01", od, om); end
        do_block(2'b00, 64'h8000000000000000, od, om, lat);
        checks++; if (od !== 64'h0000000001000000)
            begin failures++; $display("FAIL ip_single_bit got %h want 0000000001000000", od); end
        do_block(2'b11, 64'h0123456789ABCDEF, od, om, lat);
        checks++; if (od !== 64'hCC00CCFFF0AAF0AA || om !== 2'b11)
            begin failures++; $display("FAIL mode11_as_ip got %h/%b want cc00ccfff0aaf0aa/11", od, om); end
`ifdef DES_PERM_BYPASS_EN
        bexp = 64'h0123456789ABCDEF;
`else
        bexp = 64'hCC00CCFFF0AAF0AA;
`endif
        do_block(2'b10, 64'h0123456789ABCDEF, od, om, lat);
        checks++; if (od !== bexp || om !== 2'b10)
            begin failures++; $display("FAIL mode10 got %h/%b want %h/10", od, om, bexp); end
        checks++; if (lat !== int'(STAGES))
            begin failures++; $display("FAIL mode10_latency got %0d want %0d", lat, STAGES); end
    endtask

    task automatic test_back_to_back();
        int si, di, first, stalls;
        do_reset();
        si = 0; di = 0; first = -1; stalls = 0;
        for (int cyc = 0; cyc < 40 && di < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (si < 8) begin
                bus.in_valid = 1'b1;
                bus.in_mode  = vmode[si];
                bus.in_data  = vin[si];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && !bus.in_ready) stalls++;
            if (bus.in_valid && bus.in_ready) si++;
            if (bus.out_valid && bus.out_ready) begin
                if (first < 0) first = cyc;
                checks++; if (bus.out_data !== vexp[di] || bus.out_mode !== vmode[di])
                    begin failures++; $display("FAIL b2b_data[%0d] got %h/%b want %h/%b",
                        di, bus.out_data, bus.out_mode, vexp[di], vmode[di]); end
                if (di > 0) begin
                    checks++; if (cyc !== first + di)
                        begin failures++; $display("FAIL b2b_gap[%0d] got cycle %0d want %0d",
                            di, cyc, first + di); end
                end
                di++;
                exp_cnt++;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (di !== 8)
            begin failures++; $display("FAIL b2b_count got %0d want 8", di); end
        checks++; if (stalls !== 0)
            begin failures++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
        @(negedge clk);
        #1;
        checks++; if (bus.blk_count !== 4'd8)
            begin failures++; $display("FAIL b2b_blk_count got %0d want 8", bus.blk_count); end
    endtask

    task automatic test_backpressure();
        int si, di, blocked_at;
        do_reset();
        si = 0; di = 0; blocked_at = -1;
        for (int cyc = 0; cyc < 60 && di < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = (cyc >= 5);
            if (si < 8) begin
                bus.in_valid = 1'b1;
                bus.in_mode  = vmode[si];
                bus.in_data  = vin[si];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && !bus.in_ready) begin
                if (blocked_at < 0) blocked_at = si;
                // Garbage while stalled must not be captured.
                bus.in_data = ~vin[si];
                bus.in_mode = 2'b11;
            end
            if (bus.in_valid && bus.in_ready) si++;
            if (bus.out_valid && !bus.out_ready) begin
                checks++; if (bus.out_data !== vexp[di] || bus.out_mode !== vmode[di])
                    begin failures++; $display("FAIL bp_hold got %h/%b want %h/%b",
                        bus.out_data, bus.out_mode, vexp[di], vmode[di]); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++; if (bus.out_data !== vexp[di] || bus.out_mode !== vmode[di])
                    begin failures++; $display("FAIL bp_data[%0d] got %h/%b want %h/%b",
                        di, bus.out_data, bus.out_mode, vexp[di], vmode[di]); end
                di++;
                exp_cnt++;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (blocked_at !== int'(STAGES))
            begin failures++; $display("FAIL bp_in_ready_drop got %0d accepts want %0d", blocked_at, STAGES); end
        checks++; if (di !== 8)
            begin failures++; $display("FAIL bp_count got %0d want 8", di); end
        @(negedge clk);
        #1;
        checks++; if (bus.blk_count !== 4'd8)
            begin failures++; $display("FAIL bp_blk_count got %0d want 8", bus.blk_count); end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] od;
        logic [1:0]  om;
        int          lat;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = vmode[0];
        bus.in_data   = vin[0];
        @(negedge clk);
        bus.in_mode   = vmode[1];
        bus.in_data   = vin[1];
        @(negedge clk);
        bus.in_valid  = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1)
            begin failures++; $display("FAIL rstmid_preload got out_valid %b want 1", bus.out_valid); end
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0)
            begin failures++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.blk_count !== 4'd0)
            begin failures++; $display("FAIL rstmid_blk_count got %0d want 0", bus.blk_count); end
        rst = 1'b0;
        exp_cnt = '0;
        do_block(2'b00, 64'h0123456789ABCDEF, od, om, lat);
        checks++; if (od !== 64'hCC00CCFFF0AAF0AA || lat !== int'(STAGES))
            begin failures++; $display("FAIL rstmid_after got %h lat %0d want cc00ccfff0aaf0aa lat %0d",
                od, lat, STAGES); end
        @(negedge clk);
        #1;
        checks++; if (bus.blk_count !== 4'd1)
            begin failures++; $display("FAIL rstmid_after_count got %0d want 1", bus.blk_count); end
    endtask

    task automatic test_wrap();
        int si, di;
        do_reset();
        si = 0; di = 0;
        for (int cyc = 0; cyc < 60 && di < 17; cyc++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (si < 17) begin
                bus.in_valid = 1'b1;
                bus.in_mode  = vmode[si % 8];
                bus.in_data  = vin[si % 8];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && bus.in_ready) si++;
            if (bus.out_valid && bus.out_ready) begin
                checks++; if (bus.out_data !== vexp[di % 8])
                    begin failures++; $display("FAIL wrap_data[%0d] got %h want %h",
                        di, bus.out_data, vexp[di % 8]); end
                di++;
                exp_cnt++;
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (di !== 17)
            begin failures++; $display("FAIL wrap_count got %0d want 17", di); end
        @(negedge clk);
        #1;
        checks++; if (bus.blk_count !== 4'd1)
            begin failures++; $display("FAIL wrap_blk_count got %0d want 1", bus.blk_count); end
        checks++; if (bus.blk_count !== exp_cnt)
            begin failures++; $display("FAIL wrap_model_count got %0d want %0d", bus.blk_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_ip();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
